mux_arb_nx1: RTL and testbench
==============================

Name: mux_arb_nx1

Overview:
Parametrised N-input, WIDTH-bit operand selector. It succeeds the combinational 2:1 8-bit mux used in the calculator datapath. Each input channel has a valid/ready handshake. The block picks one channel per cycle using fixed-priority, round-robin or manual-select arbitration. The selected word is held in a one-deep output register with its own valid/ready handshake. It sits between the operand/result sources (keypad decoder, ALU result, memory recall) and the ALU operand or display register.

Parameters:
WIDTH, 8, data width of every channel and of the output
N, 4, number of input channels (1..16)
MODE, 1, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round robin, 2 = manual select via sel

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  channel i offers a word
in_ready  output  N  channel i word accepted this cycle (one-hot or zero)
sel  input  clog2(N) (min 1)  channel index, used only when MODE=2
out_data  output  WIDTH  registered selected word
out_chan  output  clog2(N) (min 1)  index of the channel that supplied out_data
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  downstream accepts out_data

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_chan=0, round-robin pointer=0. in_ready is combinational and reads 0 while the register is full and out_ready=0.
- Register accepts a new word when can_load = !out_valid | out_ready.
- Grant is computed combinationally from in_valid:
  - MODE 0: the lowest-index valid channel.
  - MODE 1: the first valid channel at or after the pointer, searched cyclically, so index N-1 wraps to 0.
  - MODE 2: channel sel if in_valid[sel]=1; no grant if sel>=N or in_valid[sel]=0.
- in_ready[g] = can_load & grant[g]. At most one bit of in_ready is high, and it is never high for a channel that is not valid.
- On the clock edge with can_load and a grant:
  - out_data <= that channel's word, out_chan <= g, out_valid <= 1.
  - MODE 1 only: pointer <= (g+1) mod N.
- On the clock edge with can_load and no grant: out_valid <= 1 is not set (out_valid <= 0); out_data and out_chan hold their values; the pointer holds.
- While out_valid=1 and out_ready=0, out_data and out_chan stay stable and no input is accepted.
- Latency: a word accepted in cycle t appears at the output in cycle t+1.
- Throughput: one word per cycle when out_ready stays high (simultaneous drain and load).
- Round-robin fairness: with all N channels continuously valid, grants cycle 0,1,...,N-1,0,... and no channel waits more than N-1 accepted transfers.
- The pointer advances only on an actual transfer, never on idle or stalled cycles.
- N=1: grant = in_valid[0] in every mode, the pointer stays 0, sel is ignored.
- Reset mid-transfer discards the held word. No handshake completes in the reset cycle.
- A sel change while out_valid is stalled has no effect on the held word.

Decomposition:
- Package calc_mux_pkg holds:
  - MODE_FIXED=0, MODE_RR=1, MODE_MANUAL=2
  - a function clog2_min1(n)
- Natural sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req[N], ptr, advance.
  - Outputs: one-hot grant[N], grant index.
  - Holds the pointer register.
- MODE 0 and MODE 2 grant logic stays in the top module.

Test Plan:
1. Reset with in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=0 during reset. After release, the first word comes from channel 0 with out_chan=0 in both MODE 0 and MODE 1.
2. MODE 1, all four channels valid, data 8'h10,8'h20,8'h30,8'h40, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3, one word per cycle, out_data matches each channel.
3. MODE 0, in_valid=4'b1010 -> channel 1 is always granted and channel 3 is never granted until in_valid[1] drops. Then channel 3 is granted the next cycle.
4. Backpressure: out_ready=0 for 3 cycles after a load of 8'hA5 -> out_data stays 8'hA5, out_valid stays 1, in_ready=0. After out_ready=1, the next word loads in the same cycle as the drain.
5. MODE 2, sel=2, in_valid=4'b0100 -> in_ready=4'b0100, and out_data equals channel 2 one cycle later. With sel=2 and in_valid=4'b0011 -> no grant, and out_valid falls to 0 after draining.
6. Assert rst asynchronously mid-cycle while out_valid=1 -> out_valid=0 and out_data=0 immediately (before the next clock edge), and the round-robin pointer returns to 0.

Source files
------------

// File: rtl/calc_mux_pkg.sv
// Shared constants and helpers for the calculator operand selector.
package calc_mux_pkg;

  localparam int MODE_FIXED  = 0;
  localparam int MODE_RR     = 1;
  localparam int MODE_MANUAL = 2;

  // Index width that never collapses to zero bits for single-channel builds.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_nx1_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer, cyclically.
module rr_arbiter
  import calc_mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req,
  input  logic                     advance,
  output logic [N-1:0]             grant,
  output logic [clog2_min1(N)-1:0] grant_idx
);
  localparam int IW = clog2_min1(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  // Pointer moves past the winner only when a word is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (advance)
      ptr_d = (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_arb_nx1.sv
// N-input operand selector with fixed/round-robin/manual arbitration and a
// one-deep registered output stage with valid/ready handshake.
module mux_arb_nx1
  import calc_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N*WIDTH-1:0]       in_data,
  input  logic [N-1:0]             in_valid,
  output logic [N-1:0]             in_ready,
  input  logic [clog2_min1(N)-1:0] sel,
  output logic [WIDTH-1:0]         out_data,
  output logic [clog2_min1(N)-1:0] out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
);
  localparam int IW = clog2_min1(N);

  logic [N-1:0]     fx_grant, mn_grant, rr_grant, grant;
  logic [IW-1:0]    fx_idx, mn_idx, rr_idx, g_idx;
  logic [WIDTH-1:0] g_data;
  logic             can_load, xfer;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]    out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    fx_grant = '0;
    fx_idx   = '0;
    mn_grant = '0;
    mn_idx   = '0;
    // Descending scan so the lowest valid index is the one left standing.
    for (int i = N-1; i >= 0; i--) begin
      if (in_valid[i]) begin
        fx_grant    = '0;
        fx_grant[i] = 1'b1;
        fx_idx      = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && (N == 1 || int'(sel) == i)) begin
        mn_grant[i] = 1'b1;
        mn_idx      = IW'(i);
      end
    end
  end

  rr_arbiter #(.N(N)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (xfer && (MODE == MODE_RR)),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  always_comb begin
    case (MODE)
      MODE_FIXED:  begin grant = fx_grant; g_idx = fx_idx; end
      MODE_MANUAL: begin grant = mn_grant; g_idx = mn_idx; end
      default:     begin grant = rr_grant; g_idx = rr_idx; end
    endcase
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) g_data = in_data[i*WIDTH +: WIDTH];
  end

  assign can_load = !out_valid_q || out_ready;
  assign xfer     = can_load && (|grant);
  // Nothing may look accepted while reset is holding the register empty.
  assign in_ready = (rst || !can_load) ? '0 : grant;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (can_load) begin
      out_valid_d = |grant;
      if (|grant) begin
        out_data_d = g_data;
        out_chan_d = g_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Bench for mux_arb_nx1: three 4-channel instances (one per mode) and an
// N=1 instance share stimulus; a reference model feeds per-instance queues.
module tb_mux_arb_nx1;

  typedef struct {
    logic [1:0] chan;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [1:0]  s;
    logic        r;
    logic [3:0]  efx, err, emn;
  } vec_t;

  localparam logic [31:0] D0 = 32'h40302010;
  localparam logic [31:0] DA = 32'h403020A5;
  localparam logic [31:0] D5 = 32'h4030205A;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [3:0]  vin;
  logic [1:0]  sel;
  logic        ordy;

  logic [3:0] rdy [3];
  logic [7:0] od  [3];
  logic [1:0] oc  [3];
  logic       ov  [3];

  logic [0:0] n1_rdy;
  logic [7:0] n1_od;
  logic [0:0] n1_oc;
  logic       n1_ov;

  int nvec = 0;
  int nmis = 0;

  int   mptr [3];
  bit   mvld [3];
  exp_t sb   [3][$];
  bit   n1_vld;
  logic [7:0] n1_q [$];

  vec_t tbl [25];

  always #5 clk = ~clk;

  mux_arb_nx1 #(.WIDTH(8), .N(4), .MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vin), .in_ready(rdy[0]),
    .sel(sel), .out_data(od[0]), .out_chan(oc[0]), .out_valid(ov[0]), .out_ready(ordy));
  mux_arb_nx1 #(.WIDTH(8), .N(4), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vin), .in_ready(rdy[1]),
    .sel(sel), .out_data(od[1]), .out_chan(oc[1]), .out_valid(ov[1]), .out_ready(ordy));
  mux_arb_nx1 #(.WIDTH(8), .N(4), .MODE(2)) dut_mn (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vin), .in_ready(rdy[2]),
    .sel(sel), .out_data(od[2]), .out_chan(oc[2]), .out_valid(ov[2]), .out_ready(ordy));
  mux_arb_nx1 #(.WIDTH(8), .N(1), .MODE(1)) dut_n1 (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(vin[0:0]), .in_ready(n1_rdy),
    .sel(1'b1), .out_data(n1_od), .out_chan(n1_oc), .out_valid(n1_ov), .out_ready(ordy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] mgrant(input int m, input logic [3:0] v,
                                        input logic [1:0] s, input int p);
    logic [3:0] g;
    g = '0;
    if (m == 0) begin
      if (v[0]) g = 4'b0001; else if (v[1]) g = 4'b0010;
      else if (v[2]) g = 4'b0100; else if (v[3]) g = 4'b1000;
    end else if (m == 1) begin
      for (int k = 3; k >= 0; k--)
        if (v[(p + k) % 4]) g = 4'b0001 << ((p + k) % 4);
    end else begin
      if (v[s]) g = 4'b0001 << s;
    end
    return g;
  endfunction

  function automatic int oh2idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      mptr[m] = 0;
      mvld[m] = 1'b0;
      sb[m].delete();
    end
    n1_vld = 1'b0;
    n1_q.delete();
  endtask

  // One cycle: drive, check against the model before the edge, advance model.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [1:0] s,
                      input logic r, output logic [3:0] got [3]);
    logic [3:0] er [3];
    bit         cl [3];
    bit         n1_cl;
    exp_t       e;
    vin = v; din = d; sel = s; ordy = r;
    #1;
    for (int m = 0; m < 3; m++) begin
      got[m] = rdy[m];
      chk($sformatf("m%0d out_valid", m), 32'(ov[m]), 32'(mvld[m]));
      if (mvld[m]) begin
        if (sb[m].size() == 0) chk($sformatf("m%0d sb_empty", m), 1, 0);
        else begin
          chk($sformatf("m%0d out_data", m), 32'(od[m]), 32'(sb[m][0].data));
          chk($sformatf("m%0d out_chan", m), 32'(oc[m]), 32'(sb[m][0].chan));
        end
      end
      cl[m] = !mvld[m] || r;
      er[m] = cl[m] ? mgrant(m, v, s, mptr[m]) : 4'b0000;
      chk($sformatf("m%0d in_ready", m), 32'(rdy[m]), 32'(er[m]));
    end
    n1_cl = !n1_vld || r;
    chk("n1 in_ready", 32'(n1_rdy), 32'(v[0] & n1_cl));
    chk("n1 out_valid", 32'(n1_ov), 32'(n1_vld));
    if (n1_vld && n1_q.size() > 0) begin
      chk("n1 out_data", 32'(n1_od), 32'(n1_q[0]));
      chk("n1 out_chan", 32'(n1_oc), 0);
    end
    @(posedge clk);
    for (int m = 0; m < 3; m++) begin
      if (mvld[m] && r && sb[m].size() > 0) void'(sb[m].pop_front());
      if (cl[m]) begin
        if (|er[m]) begin
          e.chan = 2'(oh2idx(er[m]));
          e.data = d[oh2idx(er[m])*8 +: 8];
          sb[m].push_back(e);
          mvld[m] = 1'b1;
          if (m == 1) mptr[m] = (oh2idx(er[m]) + 1) % 4;
        end else mvld[m] = 1'b0;
      end
    end
    if (n1_vld && r && n1_q.size() > 0) void'(n1_q.pop_front());
    if (n1_cl) begin
      n1_vld = v[0];
      if (v[0]) n1_q.push_back(d[7:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] got [3];
    // Hand-derived expected in_ready for fixed / round-robin / manual.
    tbl[0]  = '{4'b1111, D0, 2'd0, 1'b1, 4'b0001, 4'b0001, 4'b0001};
    tbl[1]  = '{4'b1111, D0, 2'd1, 1'b1, 4'b0001, 4'b0010, 4'b0010};
    tbl[2]  = '{4'b1111, D0, 2'd2, 1'b1, 4'b0001, 4'b0100, 4'b0100};
    tbl[3]  = '{4'b1111, D0, 2'd3, 1'b1, 4'b0001, 4'b1000, 4'b1000};
    tbl[4]  = '{4'b1111, D0, 2'd0, 1'b1, 4'b0001, 4'b0001, 4'b0001};
    tbl[5]  = '{4'b1111, D0, 2'd1, 1'b1, 4'b0001, 4'b0010, 4'b0010};
    tbl[6]  = '{4'b1111, D0, 2'd2, 1'b1, 4'b0001, 4'b0100, 4'b0100};
    tbl[7]  = '{4'b1111, D0, 2'd3, 1'b1, 4'b0001, 4'b1000, 4'b1000};
    tbl[8]  = '{4'b1010, D0, 2'd1, 1'b1, 4'b0010, 4'b0010, 4'b0010};
    tbl[9]  = '{4'b1010, D0, 2'd1, 1'b1, 4'b0010, 4'b1000, 4'b0010};
    tbl[10] = '{4'b1010, D0, 2'd3, 1'b1, 4'b0010, 4'b0010, 4'b1000};
    tbl[11] = '{4'b1000, D0, 2'd3, 1'b1, 4'b1000, 4'b1000, 4'b1000};
    tbl[12] = '{4'b0100, D0, 2'd2, 1'b1, 4'b0100, 4'b0100, 4'b0100};
    tbl[13] = '{4'b0011, D0, 2'd2, 1'b1, 4'b0001, 4'b0001, 4'b0000};
    tbl[14] = '{4'b0000, D0, 2'd2, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[15] = '{4'b0001, DA, 2'd0, 1'b1, 4'b0001, 4'b0001, 4'b0001};
    tbl[16] = '{4'b0001, D5, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[17] = '{4'b0001, D5, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[18] = '{4'b0001, D5, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[19] = '{4'b0001, D5, 2'd0, 1'b1, 4'b0001, 4'b0001, 4'b0001};
    tbl[20] = '{4'b0000, D0, 2'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[21] = '{4'b0100, D0, 2'd2, 1'b0, 4'b0100, 4'b0100, 4'b0100};
    tbl[22] = '{4'b0001, D0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[23] = '{4'b0001, D0, 2'd0, 1'b1, 4'b0001, 4'b0001, 4'b0001};
    tbl[24] = '{4'b0000, D0, 2'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000};

    rst = 1'b1; vin = 4'b1111; din = D0; sel = '0; ordy = 1'b0;
    model_reset();
    #12;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst m%0d out_valid", m), 32'(ov[m]), 0);
      chk($sformatf("rst m%0d out_data", m), 32'(od[m]), 0);
      chk($sformatf("rst m%0d in_ready", m), 32'(rdy[m]), 0);
    end
    chk("rst n1 in_ready", 32'(n1_rdy), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r, got);
      chk($sformatf("tbl%0d fx in_ready", i), 32'(got[0]), 32'(tbl[i].efx));
      chk($sformatf("tbl%0d rr in_ready", i), 32'(got[1]), 32'(tbl[i].err));
      chk($sformatf("tbl%0d mn in_ready", i), 32'(got[2]), 32'(tbl[i].emn));
    end

    // Load channel 1 (round-robin pointer moves to 2), then reset mid-cycle.
    step(4'b0010, D0, 2'd1, 1'b0, got);
    for (int m = 0; m < 3; m++) chk($sformatf("pre-rst m%0d out_valid", m), 32'(ov[m]), 1);
    vin = 4'b1111;
    #2 rst = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("async rst m%0d out_valid", m), 32'(ov[m]), 0);
      chk($sformatf("async rst m%0d out_data", m), 32'(od[m]), 0);
      chk($sformatf("async rst m%0d in_ready", m), 32'(rdy[m]), 0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111, D0, 2'd0, 1'b1, got);
    chk("post-rst rr ptr0 grant", 32'(got[1]), 32'(4'b0001));
    step(4'b0000, D0, 2'd0, 1'b1, got);
    chk("post-rst rr out_chan", 32'(oc[1]), 0);
    step(4'b0000, D0, 2'd0, 1'b1, got);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
